// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared widths and types for the RAM-backed byte FIFO controller
package ram_fifo_pkg;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int CW    = 7;

  typedef logic [DW-1:0] data_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - push/pop stream and single-port RAM signals of the FIFO controller
interface ram_fifo_ctrl_if;
  import ram_fifo_pkg::*;

  logic  wr_valid;
  data_t wr_data;
  logic  wr_ready;
  logic  rd_valid;
  data_t rd_data;
  logic  rd_ready;
  cnt_t  count;
  data_t ram_data;
  ptr_t  ram_addr;
  logic  ram_we;
  data_t ram_q;

  // slave: the controller; master: producer/consumer plus the RAM beside it
  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_q,
    output wr_ready, rd_valid, rd_data, count, ram_data, ram_addr, ram_we
  );

  modport master (
    output wr_valid, wr_data, rd_ready, ram_q,
    input  wr_ready, rd_valid, rd_data, count, ram_data, ram_addr, ram_we
  );

endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - byte FIFO over an external 64x8 single-port RAM with a one-entry output register
// Optional synchronous flush input clr when RAM_FIFO_CTRL_CLR_EN is defined.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ram_fifo_ctrl_if.slave bus
`ifdef RAM_FIFO_CTRL_CLR_EN
  ,
  input  logic          clr
`endif
);

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  mem_cnt_q, mem_cnt_d;
  logic  rd_pend_q, rd_pend_d;
  logic  rd_valid_q, rd_valid_d;
  data_t rd_data_q, rd_data_d;

  logic rd_issue;
  logic wr_ready;
  logic push;
  logic pop;

  // The RAM port is shared: a prefetch read takes the cycle and the push waits.
  assign rd_issue = (mem_cnt_q != '0) && !rd_pend_q && (!rd_valid_q || bus.rd_ready);
  assign wr_ready = (mem_cnt_q < cnt_t'(DEPTH)) && !rd_issue;
  assign push     = bus.wr_valid && wr_ready;
  assign pop      = rd_valid_q && bus.rd_ready;

  assign bus.wr_ready = wr_ready;
  assign bus.ram_addr = rd_issue ? rd_ptr_q : wr_ptr_q;
  assign bus.ram_we   = push;
  assign bus.ram_data = bus.wr_data;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.count    = mem_cnt_q + cnt_t'(rd_pend_q) + cnt_t'(rd_valid_q);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_cnt_d  = mem_cnt_q + cnt_t'(push) - cnt_t'(rd_issue);
    rd_pend_d  = rd_issue;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    // A read never issues while one is pending, so capture and pop cannot collide.
    if (rd_pend_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = bus.ram_q;
    end else if (pop) begin
      rd_valid_d = 1'b0;
    end

`ifdef RAM_FIFO_CTRL_CLR_EN
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mem_cnt_d  = '0;
      rd_pend_d  = 1'b0;
      rd_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule
